proc_ctrl_fsm: RTL and testbench
================================

# proc_ctrl_fsm

Instruction-sequencing control unit for the multi-cycle datapath processor. It owns its step counter, accepts a Run request, decodes the instruction register, and drives the one-hot register-file strobes, the A/G staging registers, the DIN bypass and a multi-function ALU select. It is a parametrised successor to the fixed 8-register, externally-counted control unit: register count and opcode width are generic, the control unit has its own step state machine, and an optional conditional move is supported.

## Interface
Parameters:
- NREGS, 8, number of general registers; power of two, ≥2; RA_W = clog2(NREGS)
- OP_W, 4, opcode field width (≥4)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- Resetn  in  1  synchronous, active-low reset
- Run  in  1  start request, sampled only in step T0
- ir  in  OP_W+2*RA_W  external IR contents: [OP_W+2*RA_W-1 -: OP_W]=opcode, next RA_W=X, low RA_W=Y
- Gnz  in  1  G register non-zero (used by mvnz only)
- IRin  out  1  load IR from DIN
- Rin  out  NREGS  one-hot register write enable
- Rout  out  NREGS  one-hot register bus-drive select
- DINout  out  1  drive DIN onto bus
- Ain, Gin, Gout  out  1  staging register load/drive strobes
- alu_op  out  3  ALU function: 0 add, 1 sub, 2 slt, 3 sll, 4 srl, 5 and
- Done  out  1  last cycle of an instruction
- illegal  out  1  pulses with Done for an undecodable opcode
- step  out  2  current step (T0..T3), debug

## Operation
- States T0 (fetch), T1, T2, T3; step encodes 0..3.
- T0: IRin=Run. Run=1 → T1; Run=0 → stay T0, all strobes 0.
- Opcodes: 0 add,1 sub,2 slt,3 sll,4 srl,5 and (ALU class); 6 mv; 7 mvi; 8 mvnz (macro); all others illegal.
- ALU class: T1 Rout=onehot(Y-independent X), Ain=1 → T2; T2 Rout=onehot(Y), Gin=1, alu_op=opcode[2:0] → T3; T3 Gout=1, Rin=onehot(X), Done=1 → T0.
- mv: T1 Rout=onehot(Y), Rin=onehot(X), Done=1 → T0.
- mvi: T1 DINout=1, Rin=onehot(X), Done=1 → T0.
- Illegal: T1 Done=1, illegal=1, no Rin/Ain/Gin/DINout → T0.
- alu_op is 0 outside ALU-class T2.
- Bus exclusivity: at most one of {any Rout bit, DINout, Gout} high in any cycle.

## Timing
- Outputs combinational from state and ir; ir must be stable from T1 through Done.
- Latency: ALU 4 cycles, mv/mvi/illegal 2 cycles, Run-to-IRin 0 cycles.
- Back-to-back: cycle after Done is T0; Run held high fetches next instruction there.
- Reset: Resetn=0 at an edge → T0 next cycle; while Resetn=0 all outputs 0 (IRin forced 0). Reset mid-instruction aborts with no Rin pulse afterwards.
- Run ignored outside T0.

## Configuration
- CTRL_MVNZ_EN defined: opcode 8 mvnz: T1 Rout=onehot(Y), Done=1, Rin=onehot(X) only if Gnz=1; never illegal.
- Undefined: opcode 8 illegal; Gnz unused.

## Structure
- Package proc_ctrl_pkg: opcode localparams, step enum (T0..T3), alu_op encodings.
- Sub-module reg_onehot_dec (RA_W → NREGS one-hot with enable), instantiated for X and Y.

## Test plan
- Reset: hold Resetn=0 with Run=1 two cycles → all outputs 0, step=0; release → IRin=1 same cycle.
- add R2,R5 (NREGS=8): T1 Rout=8'h04,Ain; T2 Rout=8'h20,Gin,alu_op=0; T3 Gout,Rin=8'h04,Done.
- mvi R7 then mv R1,R7 back-to-back with Run=1: Rin=8'h80+DINout, Done at cycle 1; IRin cycle 2; Rout=8'h80,Rin=8'h02,Done cycle 3.
- mvnz R3,R0 with Gnz=0 then Gnz=1 → Rin=0 then Rin=8'h08, Done both; without CTRL_MVNZ_EN → illegal=1.
- Opcode 15 → T1 Done=1, illegal=1, no write strobes; next cycle T0.
- Resetn=0 during ALU T2 → next cycle T0, no Rin/Gout pulse; NREGS=16 run repeats add with 16-bit one-hots.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg
// Shared definitions for the multi-cycle processor control unit:
//   - step_t      : instruction step encoding (T0 fetch .. T3)
//   - OPC_*       : opcode values found in the IR opcode field
//   - ALU_*       : encodings driven on alu_op
// Imported by proc_ctrl_fsm.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    // Opcodes. 0..5 form the ALU class; their low three bits are the ALU function.
    localparam int OPC_ADD  = 0;
    localparam int OPC_SUB  = 1;
    localparam int OPC_SLT  = 2;
    localparam int OPC_SLL  = 3;
    localparam int OPC_SRL  = 4;
    localparam int OPC_AND  = 5;
    localparam int OPC_MV   = 6;
    localparam int OPC_MVI  = 7;
    localparam int OPC_MVNZ = 8;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;

endpackage

// File: rtl/reg_onehot_dec.sv
// reg_onehot_dec
// Register-address to one-hot decoder with enable.
// Ports:
//   i_en      in  1      enable; all outputs 0 when low
//   i_addr    in  RA_W   register index
//   o_onehot  out NREGS  one-hot of i_addr
module reg_onehot_dec #(
    parameter int RA_W  = 3,
    parameter int NREGS = 8
) (
    input  logic             i_en,
    input  logic [RA_W-1:0]  i_addr,
    output logic [NREGS-1:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (i_addr == RA_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm
// Instruction-sequencing control unit for the multi-cycle datapath processor.
// Owns a T0..T3 step machine, decodes the external IR and drives the
// register-file, staging-register, DIN bypass and ALU-select controls.
//
// Parameters:
//   NREGS  number of general registers (power of two, >= 2)
//   OP_W   opcode field width (>= 4)
// Ports:
//   clock   in   1      rising-edge clock
//   Resetn  in   1      synchronous active-low reset
//   Run     in   1      start request, sampled only in T0
//   ir      in   IR_W   {opcode, X, Y}
//   Gnz     in   1      G register non-zero (mvnz only)
//   IRin    out  1      load IR from DIN
//   Rin     out  NREGS  one-hot register write enable
//   Rout    out  NREGS  one-hot register bus-drive select
//   DINout  out  1      drive DIN onto bus
//   Ain     out  1      load A
//   Gin     out  1      load G
//   Gout    out  1      drive G onto bus
//   alu_op  out  3      ALU function select
//   Done    out  1      last cycle of an instruction
//   illegal out  1      undecodable opcode (with Done)
//   step    out  2      current step, debug
//
// Build option: define CTRL_MVNZ_EN to enable the conditional move (opcode 8).
// Without it opcode 8 decodes as illegal and Gnz is ignored.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter  int NREGS = 8,
    parameter  int OP_W  = 4,
    localparam int RA_W  = $clog2(NREGS),
    localparam int IR_W  = OP_W + 2 * RA_W
) (
    input  logic             clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [IR_W-1:0]  ir,
    input  logic             Gnz,
    output logic             IRin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             DINout,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic [2:0]       alu_op,
    output logic             Done,
    output logic             illegal,
    output logic [1:0]       step
);

    // ---------------- IR field extraction and decode ----------------
    logic [OP_W-1:0]  w_opcode;
    logic [RA_W-1:0]  w_x;
    logic [RA_W-1:0]  w_y;
    logic [NREGS-1:0] w_x_onehot;
    logic [NREGS-1:0] w_y_onehot;

    assign w_opcode = ir[IR_W-1 -: OP_W];
    assign w_x      = ir[2*RA_W-1 -: RA_W];
    assign w_y      = ir[RA_W-1:0];

    reg_onehot_dec #(.RA_W(RA_W), .NREGS(NREGS)) u_dec_x (
        .i_en     (Resetn),
        .i_addr   (w_x),
        .o_onehot (w_x_onehot)
    );

    reg_onehot_dec #(.RA_W(RA_W), .NREGS(NREGS)) u_dec_y (
        .i_en     (Resetn),
        .i_addr   (w_y),
        .o_onehot (w_y_onehot)
    );

    logic w_is_alu;
    logic w_is_mv;
    logic w_is_mvi;
    logic w_is_mvnz;
    logic w_mvnz_we;

    // Full-width compares so upper opcode bits cannot alias onto legal opcodes.
    assign w_is_alu = (w_opcode <= OP_W'(OPC_AND));
    assign w_is_mv  = (w_opcode == OP_W'(OPC_MV));
    assign w_is_mvi = (w_opcode == OP_W'(OPC_MVI));

`ifdef CTRL_MVNZ_EN
    assign w_is_mvnz = (w_opcode == OP_W'(OPC_MVNZ));
    assign w_mvnz_we = Gnz;
`else
    logic w_unused_gnz;
    assign w_is_mvnz    = 1'b0;
    assign w_mvnz_we    = 1'b0;
    assign w_unused_gnz = Gnz;
`endif

    // ---------------- state register ----------------
    step_t r_step;
    step_t w_step_next;

    always_ff @(posedge clock) begin
        if (!Resetn) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_step_next = r_step;
        case (r_step)
            T0:      w_step_next = Run ? T1 : T0;
            T1:      w_step_next = w_is_alu ? T2 : T0;
            T2:      w_step_next = T3;
            T3:      w_step_next = T0;
            default: w_step_next = T0;
        endcase
    end

    // ---------------- output logic ----------------
    logic             w_irin;
    logic [NREGS-1:0] w_rin;
    logic [NREGS-1:0] w_rout;
    logic             w_dinout;
    logic             w_ain;
    logic             w_gin;
    logic             w_gout;
    logic [2:0]       w_alu_op;
    logic             w_done;
    logic             w_illegal;

    always_comb begin
        w_irin    = 1'b0;
        w_rin     = '0;
        w_rout    = '0;
        w_dinout  = 1'b0;
        w_ain     = 1'b0;
        w_gin     = 1'b0;
        w_gout    = 1'b0;
        w_alu_op  = ALU_ADD;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (r_step)
            T0: begin
                w_irin = Run;
            end
            T1: begin
                if (w_is_alu) begin
                    w_rout = w_x_onehot;
                    w_ain  = 1'b1;
                end else if (w_is_mv) begin
                    w_rout = w_y_onehot;
                    w_rin  = w_x_onehot;
                    w_done = 1'b1;
                end else if (w_is_mvi) begin
                    w_dinout = 1'b1;
                    w_rin    = w_x_onehot;
                    w_done   = 1'b1;
                end else if (w_is_mvnz) begin
                    w_rout = w_y_onehot;
                    w_rin  = w_mvnz_we ? w_x_onehot : '0;
                    w_done = 1'b1;
                end else begin
                    w_done    = 1'b1;
                    w_illegal = 1'b1;
                end
            end
            T2: begin
                w_rout = w_y_onehot;
                w_gin  = 1'b1;
                // Only ALU-class instructions reach T2; guard keeps alu_op 0 if
                // the IR is disturbed mid-instruction.
                w_alu_op = w_is_alu ? w_opcode[2:0] : ALU_ADD;
            end
            T3: begin
                w_gout = 1'b1;
                w_rin  = w_x_onehot;
                w_done = 1'b1;
            end
            default: begin
                w_irin = 1'b0;
            end
        endcase
    end

    // Outputs are held at zero for the whole time Resetn is low, including the
    // cycle in which reset is first asserted, so an aborted instruction never
    // produces a write strobe.
    assign IRin    = Resetn & w_irin;
    assign Rin     = Resetn ? w_rin  : '0;
    assign Rout    = Resetn ? w_rout : '0;
    assign DINout  = Resetn & w_dinout;
    assign Ain     = Resetn & w_ain;
    assign Gin     = Resetn & w_gin;
    assign Gout    = Resetn & w_gout;
    assign alu_op  = Resetn ? w_alu_op : 3'd0;
    assign Done    = Resetn & w_done;
    assign illegal = Resetn & w_illegal;
    assign step    = Resetn ? r_step : 2'd0;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
module tb_proc_ctrl_fsm;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // ---------------- NREGS=8 instance ----------------
    logic        rstn8, run8, gnz8;
    logic [9:0]  ir8_s;
    logic        irin8, dinout8, ain8, gin8, gout8, done8, ill8;
    logic [7:0]  rin8, rout8;
    logic [2:0]  alu8;
    logic [1:0]  step8;

    proc_ctrl_fsm #(.NREGS(8), .OP_W(4)) dut8 (
        .clock   (clock),
        .Resetn  (rstn8),
        .Run     (run8),
        .ir      (ir8_s),
        .Gnz     (gnz8),
        .IRin    (irin8),
        .Rin     (rin8),
        .Rout    (rout8),
        .DINout  (dinout8),
        .Ain     (ain8),
        .Gin     (gin8),
        .Gout    (gout8),
        .alu_op  (alu8),
        .Done    (done8),
        .illegal (ill8),
        .step    (step8)
    );

    // ---------------- NREGS=16 instance ----------------
    logic        rstn16, run16, gnz16;
    logic [11:0] ir16_s;
    logic        irin16, dinout16, ain16, gin16, gout16, done16, ill16;
    logic [15:0] rin16, rout16;
    logic [2:0]  alu16;
    logic [1:0]  step16;

    proc_ctrl_fsm #(.NREGS(16), .OP_W(4)) dut16 (
        .clock   (clock),
        .Resetn  (rstn16),
        .Run     (run16),
        .ir      (ir16_s),
        .Gnz     (gnz16),
        .IRin    (irin16),
        .Rin     (rin16),
        .Rout    (rout16),
        .DINout  (dinout16),
        .Ain     (ain16),
        .Gin     (gin16),
        .Gout    (gout16),
        .alu_op  (alu16),
        .Done    (done16),
        .illegal (ill16),
        .step    (step16)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       rstn;
        logic       run;
        logic [9:0] ir;
        logic       gnz;
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic [3:0] strb;   // {DINout, Ain, Gin, Gout}
        logic [2:0] alu;
        logic       done;
        logic       ill;
        logic [1:0] step;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rstn, logic run, logic [9:0] ir, logic gnz,
                               logic irin, logic [7:0] rin, logic [7:0] rout,
                               logic [3:0] strb, logic [2:0] alu, logic done,
                               logic ill, logic [1:0] st);
        vec_t r;
        r.rstn = rstn; r.run = run; r.ir = ir; r.gnz = gnz;
        r.irin = irin; r.rin = rin; r.rout = rout; r.strb = strb;
        r.alu = alu; r.done = done; r.ill = ill; r.step = st;
        return r;
    endfunction

    function automatic logic [9:0] mk_ir8(int op, int x, int y);
        logic [3:0] o;
        logic [2:0] xa, ya;
        o  = op[3:0];
        xa = x[2:0];
        ya = y[2:0];
        return {o, xa, ya};
    endfunction

    function automatic logic [7:0] oh8(int idx);
        logic [7:0] r;
        r = 8'd1 << idx;
        return r;
    endfunction

    // Four-row ALU-class instruction starting from T0 with Run=1.
    task automatic push_alu(int op, int x, int y);
        logic [9:0] ir;
        logic [3:0] opv;
        ir  = mk_ir8(op, x, y);
        opv = op[3:0];
        vecs.push_back(v(1, 1, ir, 0, 1, 8'h00, 8'h00,  4'b0000, 3'd0,     0, 0, 2'd0));
        vecs.push_back(v(1, 0, ir, 0, 0, 8'h00, oh8(x), 4'b0100, 3'd0,     0, 0, 2'd1));
        vecs.push_back(v(1, 0, ir, 0, 0, 8'h00, oh8(y), 4'b0010, opv[2:0], 0, 0, 2'd2));
        vecs.push_back(v(1, 0, ir, 0, 0, oh8(x), 8'h00, 4'b0001, 3'd0,     1, 0, 2'd3));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [9:0] add25, mvi7, mv17, ill15, ill9, mvnz30;
        int bus;

        rstn8 = 0; run8 = 0; ir8_s = '0; gnz8 = 0;
        rstn16 = 0; run16 = 0; ir16_s = '0; gnz16 = 0;

        add25  = mk_ir8(0, 2, 5);
        mvi7   = mk_ir8(7, 7, 0);
        mv17   = mk_ir8(6, 1, 7);
        ill15  = mk_ir8(15, 3, 4);
        ill9   = mk_ir8(9, 1, 2);
        mvnz30 = mk_ir8(8, 3, 0);

        // Reset held with Run=1, then release: IRin high in the same cycle.
        vecs.push_back(v(0, 1, add25, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(0, 1, add25, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        // add R2,R5 ; Run=1 during T1 must be ignored
        vecs.push_back(v(1, 1, add25, 0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 1, add25, 0, 0, 8'h00, 8'h04, 4'b0100, 3'd0, 0, 0, 2'd1));
        vecs.push_back(v(1, 0, add25, 0, 0, 8'h00, 8'h20, 4'b0010, 3'd0, 0, 0, 2'd2));
        vecs.push_back(v(1, 0, add25, 0, 0, 8'h04, 8'h00, 4'b0001, 3'd0, 1, 0, 2'd3));
        // mvi R7 then mv R1,R7 back-to-back
        vecs.push_back(v(1, 1, mvi7, 0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 1, mvi7, 0, 0, 8'h80, 8'h00, 4'b1000, 3'd0, 1, 0, 2'd1));
        vecs.push_back(v(1, 1, mv17, 0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 1, mv17, 0, 0, 8'h02, 8'h80, 4'b0000, 3'd0, 1, 0, 2'd1));
        // Idle in T0
        vecs.push_back(v(1, 0, mv17, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, mv17, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        // Remaining ALU functions
        push_alu(1, 6, 1);
        push_alu(2, 3, 4);
        push_alu(3, 7, 0);
        push_alu(4, 0, 7);
        push_alu(5, 5, 2);
        // Illegal opcodes 15 and 9
        vecs.push_back(v(1, 1, ill15, 0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, ill15, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 1, 1, 2'd1));
        vecs.push_back(v(1, 1, ill9,  0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        vecs.push_back(v(1, 0, ill9,  0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 1, 1, 2'd1));
        vecs.push_back(v(1, 0, ill9,  0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
        // mvnz R3,R0 with Gnz=0 then Gnz=1
        vecs.push_back(v(1, 1, mvnz30, 0, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
`ifdef CTRL_MVNZ_EN
        vecs.push_back(v(1, 0, mvnz30, 0, 0, 8'h00, 8'h01, 4'b0000, 3'd0, 1, 0, 2'd1));
`else
        vecs.push_back(v(1, 0, mvnz30, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 1, 1, 2'd1));
`endif
        vecs.push_back(v(1, 1, mvnz30, 1, 1, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));
`ifdef CTRL_MVNZ_EN
        vecs.push_back(v(1, 0, mvnz30, 1, 0, 8'h08, 8'h01, 4'b0000, 3'd0, 1, 0, 2'd1));
`else
        vecs.push_back(v(1, 0, mvnz30, 1, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 1, 1, 2'd1));
`endif
        vecs.push_back(v(1, 0, mvnz30, 0, 0, 8'h00, 8'h00, 4'b0000, 3'd0, 0, 0, 2'd0));

        // ---------------- table-driven section ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            rstn8 = vecs[i].rstn;
            run8  = vecs[i].run;
            ir8_s = vecs[i].ir;
            gnz8  = vecs[i].gnz;
            #1;
            $display("vec %0d rstn=%0b run=%0b ir=%03h gnz=%0b -> step=%0d irin=%0b rin=%02h rout=%02h strb=%0b%0b%0b%0b alu=%0d done=%0b ill=%0b",
                     i, rstn8, run8, ir8_s, gnz8, step8, irin8, rin8, rout8,
                     dinout8, ain8, gin8, gout8, alu8, done8, ill8);
            chk($sformatf("v%0d_irin", i), 32'(irin8), 32'(vecs[i].irin));
            chk($sformatf("v%0d_rin", i), 32'(rin8), 32'(vecs[i].rin));
            chk($sformatf("v%0d_rout", i), 32'(rout8), 32'(vecs[i].rout));
            chk($sformatf("v%0d_strobes", i), 32'({dinout8, ain8, gin8, gout8}), 32'(vecs[i].strb));
            chk($sformatf("v%0d_alu_op", i), 32'(alu8), 32'(vecs[i].alu));
            chk($sformatf("v%0d_done_ill", i), 32'({done8, ill8}), 32'({vecs[i].done, vecs[i].ill}));
            chk($sformatf("v%0d_step", i), 32'(step8), 32'(vecs[i].step));
            bus = $countones(rout8) + int'(dinout8) + int'(gout8);
            chk($sformatf("v%0d_bus_excl", i), 32'(bus <= 1), 32'd1);
        end

        // ---------------- reset during ALU T2 ----------------
        @(negedge clock);
        rstn8 = 1; run8 = 1; ir8_s = mk_ir8(0, 1, 6); #1;
        $display("seq abort T0 step=%0d irin=%0b", step8, irin8);
        chk("abort_irin", 32'(irin8), 32'd1);
        @(negedge clock);
        run8 = 0; #1;
        $display("seq abort T1 step=%0d rout=%02h", step8, rout8);
        chk("abort_t1_rout", 32'(rout8), 32'h02);
        @(negedge clock);
        #1;
        $display("seq abort T2 step=%0d gin=%0b", step8, gin8);
        chk("abort_t2_step", 32'(step8), 32'd2);
        rstn8 = 0; #1;
        $display("seq abort T2+reset rin=%02h rout=%02h gin=%0b gout=%0b", rin8, rout8, gin8, gout8);
        chk("abort_rst_outs", 32'({rin8, rout8, gin8, gout8, done8}), 32'd0);
        @(negedge clock);
        rstn8 = 1; #1;
        $display("seq abort post step=%0d rin=%02h gout=%0b done=%0b", step8, rin8, gout8, done8);
        chk("abort_post_step", 32'(step8), 32'd0);
        chk("abort_post_wr", 32'({rin8, gout8, done8}), 32'd0);
        @(negedge clock);
        #1;
        $display("seq abort idle step=%0d rin=%02h", step8, rin8);
        chk("abort_idle_step", 32'(step8), 32'd0);
        chk("abort_idle_rin", 32'(rin8), 32'd0);

        // ---------------- NREGS=16: add R10,R3 then mv R15,R12 ----------------
        @(negedge clock);
        rstn16 = 1; run16 = 1; ir16_s = {4'd0, 4'd10, 4'd3}; #1;
        $display("seq n16 T0 step=%0d irin=%0b", step16, irin16);
        chk("n16_irin", 32'(irin16), 32'd1);
        @(negedge clock);
        run16 = 0; #1;
        $display("seq n16 T1 rout=%04h ain=%0b", rout16, ain16);
        chk("n16_t1_rout", 32'(rout16), 32'h0400);
        chk("n16_t1_ain", 32'(ain16), 32'd1);
        @(negedge clock);
        #1;
        $display("seq n16 T2 rout=%04h gin=%0b alu=%0d", rout16, gin16, alu16);
        chk("n16_t2_rout", 32'(rout16), 32'h0008);
        chk("n16_t2_gin", 32'(gin16), 32'd1);
        @(negedge clock);
        #1;
        $display("seq n16 T3 rin=%04h gout=%0b done=%0b", rin16, gout16, done16);
        chk("n16_t3_rin", 32'(rin16), 32'h0400);
        chk("n16_t3_gout_done", 32'({gout16, done16}), 32'b11);
        @(negedge clock);
        run16 = 1; ir16_s = {4'd6, 4'd15, 4'd12}; #1;
        $display("seq n16 mv T0 step=%0d irin=%0b", step16, irin16);
        chk("n16_mv_t0_step", 32'(step16), 32'd0);
        @(negedge clock);
        run16 = 0; #1;
        $display("seq n16 mv T1 rout=%04h rin=%04h done=%0b", rout16, rin16, done16);
        chk("n16_mv_rout", 32'(rout16), 32'h1000);
        chk("n16_mv_rin", 32'(rin16), 32'h8000);
        chk("n16_mv_done", 32'({done16, ill16}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
